// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU command sequencer and its wait counter.
package alu_seq_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_DR,
        S_LD_MQ,
        S_LD_ACC,
        S_ISSUE,
        S_WAIT,
        S_RD_ACC,
        S_RD_MQ,
        S_RESP
    } seq_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              err;
    } alu_rsp_t;

endpackage

// File: rtl/alu_seq_wdog.sv
// WAIT-state cycle counter: reports when RDY may be honoured and when the wait has run out.
module alu_seq_wdog #(
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned MIN_WAIT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic past_min,
    output logic expired
);

    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [7:0] MIN_WAIT_C = 8'(MIN_WAIT);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Saturates so a stalled enable can never wrap back below the limits.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign past_min = (count_q >= MIN_WAIT_C);
    assign expired  = (count_q >= TIMEOUT_C);

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end that loads operands into the Acc/MQ/DR datapath, issues one opcode,
// waits for RDY or timeout, then reads Acc and MQ back as a single response.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned MIN_WAIT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [DATA_W-1:0] cmd_acc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_hi,
    output logic [DATA_W-1:0] rsp_lo,
    output logic              rsp_err,
    output logic [OP_W-1:0]   INS,
    output logic              LDAcc,
    output logic              LDMQ,
    output logic              LDDR,
    output logic              STAcc,
    output logic              STMQ,
    output logic              STDR,
    output logic              TESTMODE,
    output logic [DATA_W-1:0] inBUS,
    input  logic [DATA_W-1:0] outBUS,
    input  logic              RDY
);

    seq_state_e        state_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] acc_q;
    alu_rsp_t          rsp_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [OP_W-1:0]   ins_q;
    logic [DATA_W-1:0] inbus_q;
    logic              ldacc_q;
    logic              ldmq_q;
    logic              lddr_q;
    logic              stacc_q;
    logic              stmq_q;
    logic              past_min;
    logic              expired;

    alu_seq_wdog #(
        .TIMEOUT  (TIMEOUT),
        .MIN_WAIT (MIN_WAIT)
    ) u_wdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_q == S_ISSUE),
        .enable   (state_q == S_WAIT),
        .past_min (past_min),
        .expired  (expired)
    );

    // Datapath outputs are computed for the state being entered, so each
    // strobe/bus value is a flop that lines up with its state cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            rsp_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            ins_q       <= '0;
            inbus_q     <= '0;
            ldacc_q     <= 1'b0;
            ldmq_q      <= 1'b0;
            lddr_q      <= 1'b0;
            stacc_q     <= 1'b0;
            stmq_q      <= 1'b0;
        end else begin
            ins_q   <= '0;
            inbus_q <= '0;
            ldacc_q <= 1'b0;
            ldmq_q  <= 1'b0;
            lddr_q  <= 1'b0;
            stacc_q <= 1'b0;
            stmq_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        b_q         <= cmd_b;
                        acc_q       <= cmd_acc;
                        rsp_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        lddr_q      <= 1'b1;
                        inbus_q     <= cmd_a;
                        state_q     <= S_LD_DR;
                    end
                end
                S_LD_DR: begin
                    ldmq_q  <= 1'b1;
                    inbus_q <= b_q;
                    state_q <= S_LD_MQ;
                end
                S_LD_MQ: begin
                    ldacc_q <= 1'b1;
                    inbus_q <= acc_q;
                    state_q <= S_LD_ACC;
                end
                S_LD_ACC: begin
                    ins_q   <= op_q;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    ins_q   <= op_q;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // RDY is checked before expiry so a same-cycle RDY still completes.
                    if (past_min && RDY) begin
                        stacc_q <= 1'b1;
                        state_q <= S_RD_ACC;
                    end else if (expired) begin
                        rsp_q.err   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        ins_q <= op_q;
                    end
                end
                S_RD_ACC: begin
                    rsp_q.hi <= outBUS;
                    stmq_q   <= 1'b1;
                    state_q  <= S_RD_MQ;
                end
                S_RD_MQ: begin
                    rsp_q.lo    <= outBUS;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hi    = rsp_q.hi;
    assign rsp_lo    = rsp_q.lo;
    assign rsp_err   = rsp_q.err;
    assign INS       = ins_q;
    assign inBUS     = inbus_q;
    assign LDAcc     = ldacc_q;
    assign LDMQ      = ldmq_q;
    assign LDDR      = lddr_q;
    assign STAcc     = stacc_q;
    assign STMQ      = stmq_q;
    assign STDR      = 1'b0;
    assign TESTMODE  = 1'b0;

endmodule
